mont_mul_arbiter: RTL and testbench
===================================

# mont_mul_arbiter

Shares one Montgomery multiplier datapath between NREQ independent requesters, such as the exponentiation and key-setup engines. It runs round-robin arbitration and holds the granted operands stable for the whole operation. It launches the multiplier with a one-cycle enable pulse, waits for its done pulse, and routes the result back to the owner. A watchdog bounds each operation and reports a stuck datapath as an error instead of hanging the requesters.

## Interface
- NBITS, 4096, operand/modulus width; matches the multiplier instance.
- NREQ, 4, number of requesters, 2..8.
- TMO_CYCLES, 65536, watchdog limit in cycles per operation; ≥ 2.
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held until accepted.
- req_ready  out  NREQ  one-hot accept; combinational from state, pointer and req_valid.
- req_a, req_b, req_m  in  NREQ*NBITS each  flattened operands; slice i belongs to requester i.
- rsp_valid  out  NREQ  one-hot, one-cycle response pulse to the owner.
- rsp_y  out  NBITS  result; valid only while rsp_valid is nonzero.
- rsp_err  out  1  qualifies rsp_valid; 1 means timeout.
- busy  out  1  high from accept until return to IDLE.
- owner  out  $clog2(NREQ)  index of the current or last owner.
- mm_enable_p  out  1  one-cycle launch pulse to the multiplier.
- mm_a, mm_b, mm_m  out  NBITS each  registered operands, stable from launch until completion.
- mm_y  in  NBITS  multiplier result.
- mm_done_irq_p  in  1  one-cycle completion pulse.

## Operation
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_y=0, rsp_err=0, busy=0, owner=0.
  - mm_enable_p=0, mm_a/b/m=0.
  - RR pointer=0, state=IDLE, timer=0.
- FSM states: IDLE, LAUNCH, WAIT, RESP, DRAIN.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the pointer upward with wrap.
  - Assert req_ready for the winner only.
  - Latch its slices into mm_a/b/m, set owner, go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: mm_enable_p=1, timer cleared, go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - On mm_done_irq_p: capture mm_y into rsp_y, clear rsp_err, go to RESP.
  - Else if timer==TMO_CYCLES-1: set rsp_y=0 and rsp_err=1, go to RESP.
  - Done has priority over timeout in the same cycle.
- RESP:
  - rsp_valid[owner]=1 for one cycle.
  - Pointer = owner+1, wrapping at NREQ.
  - If rsp_err=0, go to IDLE. If rsp_err=1, clear the timer and go to DRAIN.
- DRAIN:
  - Absorbs a stale completion.
  - Exit to IDLE on mm_done_irq_p (result discarded) or when timer==TMO_CYCLES-1.
  - mm_a/b/m are held throughout.
- rsp_y and rsp_err hold their value after RESP until the next capture.
- mm_done_irq_p is ignored in IDLE and LAUNCH.
- A requester may drop req_valid before it is accepted; no commitment exists until req_valid & req_ready.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - The in-flight requester receives no response.
  - The multiplier shares rst with this block, so it is reset too.

## Timing
- Accept at cycle T.
- mm_enable_p at T+1.
- Done at T+1+D, where D is the multiplier latency.
- rsp_valid at T+2+D.
- Next accept no earlier than T+3+D; a requester may reassert in the rsp_valid cycle.
- Timeout: rsp_valid at T+1+TMO_CYCLES+1, i.e. TMO_CYCLES cycles after the launch pulse plus one.
- Fairness: with all NREQ requesting continuously, each requester is served once every NREQ operations.

## Structure
- Package mont_arb_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP, DRAIN);
  - localparam IDXW = $clog2(NREQ);
  - the timer width, $clog2(TMO_CYCLES).
- Sub-module mont_rr_arb: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, index, any.
- Parent keeps the FSM, operand registers, timer and response registers.

## Test plan
Bench uses a behavioural multiplier stub, NBITS=64, NREQ=4, TMO_CYCLES=64.
- **Single request, stub D=20.** Requester 2 sends a=5, b=7, m=0xFFFF_FFFF_FFFF_FF01; stub returns y=0x23. Required: req_ready[2] at T, mm_enable_p at T+1, rsp_valid=4'b0100 at T+22, rsp_y=0x23, rsp_err=0.
- **All four request from reset.** Required: grants in order 0,1,2,3; each rsp_valid goes only to its owner.
- **Fairness.** Requesters 1 and 3 request continuously. Required: grants alternate 1,3,1,3; pointer after each response is owner+1.
- **Stuck stub.** Stub never returns done. Required: rsp_valid with rsp_err=1 and rsp_y=0 at launch+64+1, then DRAIN for 64 cycles, then busy=0 and the next grant proceeds.
- **Simultaneous done and timeout.** Done arrives in the same cycle timer==63. Required: rsp_err=0 and rsp_y equals the stub result.
- **Reset in WAIT.** Assert rst during WAIT. Required: all outputs 0 immediately, no rsp_valid; a stale done after reset release is ignored; the next grant goes to requester 0.

Source files
------------

// File: rtl/mont_arb_pkg.sv
// Shared definitions for the Montgomery multiplier arbiter.
//   arb_state_e  : controller states (IDLE, LAUNCH, WAIT, RESP, DRAIN)
//   idx_width()  : requester index width, $clog2(NREQ)
//   tmr_width()  : watchdog timer width, $clog2(TMO_CYCLES)
// The widths depend on the parameters of each arbiter instance, so the
// package provides them as constant functions. Each instance turns them into
// its own IDXW/TMRW localparams.
package mont_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    DRAIN
  } arb_state_e;

  function automatic int idx_width(input int nreq);
    return $clog2(nreq);
  endfunction

  function automatic int tmr_width(input int tmo_cycles);
    return $clog2(tmo_cycles);
  endfunction

endpackage

// File: rtl/mont_rr_arb.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority requester index for this pick
//   gnt : one-hot grant, the first set bit at or above ptr, with wrap
//   idx : binary index of the granted requester
//   any : at least one request is set
module mont_rr_arb #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one Montgomery multiplier between NREQ requesters.
// It arbitrates round-robin and holds the winner's operands in mm_a/b/m.
// It launches the multiplier with mm_enable_p, waits for mm_done_irq_p, and
// returns the result to the owner as a one-cycle rsp_valid pulse. A watchdog
// of TMO_CYCLES cycles turns a stuck datapath into an error response.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req_valid/ready   : per-requester handshake, ready is one-hot
//   req_a/b/m         : flattened operands, slice i belongs to requester i
//   rsp_valid         : one-hot response pulse to the owner
//   rsp_y, rsp_err    : result and timeout flag, held until the next capture
//   busy, owner       : operation in progress, current or last owner index
//   mm_enable_p       : launch pulse to the multiplier
//   mm_a/b/m          : operands driven to the multiplier
//   mm_y              : result returned by the multiplier
//   mm_done_irq_p     : completion pulse from the multiplier
module mont_mul_arbiter
  import mont_arb_pkg::*;
#(
  parameter int NBITS      = 4096,
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 65536
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*NBITS-1:0]     req_a,
  input  logic [NREQ*NBITS-1:0]     req_b,
  input  logic [NREQ*NBITS-1:0]     req_m,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [NBITS-1:0]          rsp_y,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      mm_enable_p,
  output logic [NBITS-1:0]          mm_a,
  output logic [NBITS-1:0]          mm_b,
  output logic [NBITS-1:0]          mm_m,
  input  logic [NBITS-1:0]          mm_y,
  input  logic                      mm_done_irq_p
);

  localparam int IDXW = idx_width(NREQ);
  localparam int TMRW = tmr_width(TMO_CYCLES);
  localparam logic [TMRW-1:0] TMR_LAST = TMRW'(TMO_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);

  arb_state_e       state, state_nxt;
  logic [IDXW-1:0]  ptr;
  logic [TMRW-1:0]  timer;
  logic             tmr_last;
  logic [NREQ-1:0]  gnt;
  logic [IDXW-1:0]  gidx;
  logic             gany;
  logic [NBITS-1:0] sel_a, sel_b, sel_m;

  mont_rr_arb #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign tmr_last = (timer == TMR_LAST);

  // Operand slice of the current winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_m = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDXW'(i)) begin
        sel_a = req_a[i*NBITS +: NBITS];
        sel_b = req_b[i*NBITS +: NBITS];
        sel_m = req_m[i*NBITS +: NBITS];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Done wins over the watchdog when both occur in the same WAIT cycle.
  // Done is ignored in IDLE and LAUNCH.
  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    rsp_valid   = '0;
    mm_enable_p = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      IDLE: begin
        // Gated by rst so that no accept is shown while reset is asserted.
        if (!rst) req_ready = gnt;
        if (gany) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        mm_enable_p = 1'b1;
        state_nxt   = WAIT;
      end
      WAIT: begin
        if (mm_done_irq_p || tmr_last) state_nxt = RESP;
      end
      RESP: begin
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = (owner == IDXW'(i));
        state_nxt = rsp_err ? DRAIN : IDLE;
      end
      DRAIN: begin
        // After a timeout, wait out a late completion so that it cannot
        // be taken as the result of the next operation.
        if (mm_done_irq_p || tmr_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_a    <= '0;
      mm_b    <= '0;
      mm_m    <= '0;
      owner   <= '0;
      ptr     <= '0;
      timer   <= '0;
      rsp_y   <= '0;
      rsp_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gany) begin
            mm_a  <= sel_a;
            mm_b  <= sel_b;
            mm_m  <= sel_m;
            owner <= gidx;
          end
        end
        LAUNCH: timer <= '0;
        WAIT: begin
          timer <= timer + 1'b1;
          if (mm_done_irq_p) begin
            rsp_y   <= mm_y;
            rsp_err <= 1'b0;
          end else if (tmr_last) begin
            rsp_y   <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: begin
          ptr <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
          if (rsp_err) timer <= '0;
        end
        DRAIN: timer <= timer + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed bench for mont_mul_arbiter: NBITS=64, NREQ=4, TMO_CYCLES=64,
// with a behavioural multiplier stub of programmable latency.
module tb_mont_mul_arbiter;

  localparam int NB = 64;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*NB-1:0] req_a = '0, req_b = '0, req_m = '0;
  logic [NR-1:0]   rsp_valid;
  logic [NB-1:0]   rsp_y;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      owner;
  logic            mm_enable_p;
  logic [NB-1:0]   mm_a, mm_b, mm_m;
  logic [NB-1:0]   mm_y;
  logic            mm_done_irq_p;

  int nvec  = 0;
  int nmiss = 0;

  // Multiplier stub: done arrives stub_d cycles after the enable pulse;
  // stub_d == 0 never answers. force_done injects a pulse directly.
  int          stub_d = 0;
  logic [NB-1:0] stub_y = '0;
  logic        force_done = 1'b0;
  logic        pend;
  int          cnt;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (mm_enable_p && stub_d > 0) begin
      pend <= 1'b1;
      cnt  <= stub_d - 1;
    end else if (pend) begin
      if (cnt == 0) pend <= 1'b0;
      else          cnt  <= cnt - 1;
    end
  end

  assign mm_done_irq_p = (pend && cnt == 0) || force_done;
  assign mm_y          = stub_y;

  mont_mul_arbiter #(
    .NBITS      (NB),
    .NREQ       (NR),
    .TMO_CYCLES (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_m         (req_m),
    .rsp_valid     (rsp_valid),
    .rsp_y         (rsp_y),
    .rsp_err       (rsp_err),
    .busy          (busy),
    .owner         (owner),
    .mm_enable_p   (mm_enable_p),
    .mm_a          (mm_a),
    .mm_b          (mm_b),
    .mm_m          (mm_m),
    .mm_y          (mm_y),
    .mm_done_irq_p (mm_done_irq_p)
  );

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [63:0] a, b, m, y;
    int          d;      // stub latency, 0 = stuck
    int          idx;    // expected winner
    int          lat;    // cycles from accept to rsp_valid
    bit          err;
    int          drain;  // cycles busy stays high after the response
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_vec(input vec_t v);
    logic [63:0] ey;
    int lat;
    int bad;
    ey = v.err ? 64'h0 : v.y;
    if (v.rst_before) begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
    end
    stub_d = v.d;
    stub_y = v.y;
    for (int i = 0; i < NR; i++) begin
      req_a[i*NB +: NB] = (i == v.idx) ? v.a : {32'hBAD0_000A, i};
      req_b[i*NB +: NB] = (i == v.idx) ? v.b : {32'hBAD0_000B, i};
      req_m[i*NB +: NB] = (i == v.idx) ? v.m : {32'hBAD0_000C, i};
    end
    req_valid = v.req;
    #1;
    chk("ready", 64'(req_ready), 64'(4'b0001 << v.idx));
    tick(); #1;
    chk("launch", 64'(mm_enable_p), 64'd1);
    chk("busy", 64'(busy), 64'd1);
    chk("ready_busy", 64'(req_ready), 64'd0);
    chk("mm_a", mm_a, v.a);
    chk("mm_b", mm_b, v.b);
    chk("mm_m", mm_m, v.m);
    chk("owner", 64'(owner), 64'(v.idx));
    tick(); #1;
    chk("launch_pulse", 64'(mm_enable_p), 64'd0);
    lat = 0;
    for (int k = 3; k <= v.lat + 4; k++) begin
      tick(); #1;
      if (rsp_valid !== 4'b0) begin
        lat = k;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(v.lat));
    chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << v.idx));
    chk("rsp_y", rsp_y, ey);
    chk("rsp_err", 64'(rsp_err), 64'(v.err));
    if (v.drain > 0) begin
      bad = 0;
      for (int k = 0; k < v.drain; k++) begin
        tick(); #1;
        if (busy !== 1'b1 || rsp_valid !== 4'b0 || mm_a !== v.a) bad++;
      end
      chk("drain_cycles", 64'(bad), 64'd0);
    end
    tick(); #1;
    chk("idle", 64'(busy), 64'd0);
    chk("rsp_clear", 64'(rsp_valid), 64'd0);
    chk("y_hold", rsp_y, ey);
    chk("err_hold", 64'(rsp_err), 64'(v.err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int bad;
    //           rst  req      a          b          m                       y           d   idx lat err drain
    tbl[0]  = '{1'b0, 4'b0100, 64'd5,     64'd7,     64'hFFFF_FFFF_FFFF_FF01, 64'h23,     20, 2, 22, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'b1111, 64'h11,    64'h12,    64'h13,                 64'h1111,   1,  0, 3,  1'b0, 0};
    tbl[2]  = '{1'b0, 4'b1111, 64'h21,    64'h22,    64'h23,                 64'h2222,   3,  1, 5,  1'b0, 0};
    tbl[3]  = '{1'b0, 4'b1111, 64'h31,    64'h32,    64'h33,                 64'h3333,   5,  2, 7,  1'b0, 0};
    tbl[4]  = '{1'b0, 4'b1111, 64'h41,    64'h42,    64'h43,                 64'h4444,   2,  3, 4,  1'b0, 0};
    tbl[5]  = '{1'b0, 4'b1010, 64'h51,    64'h52,    64'h53,                 64'h5555,   4,  1, 6,  1'b0, 0};
    tbl[6]  = '{1'b0, 4'b1010, 64'h61,    64'h62,    64'h63,                 64'h6666,   6,  3, 8,  1'b0, 0};
    tbl[7]  = '{1'b0, 4'b1010, 64'h71,    64'h72,    64'h73,                 64'h7777,   2,  1, 4,  1'b0, 0};
    tbl[8]  = '{1'b0, 4'b1010, 64'h81,    64'h82,    64'h83,                 64'h8888,   3,  3, 5,  1'b0, 0};
    tbl[9]  = '{1'b0, 4'b0001, 64'h91,    64'h92,    64'h93,                 64'h9999,   0,  0, 66, 1'b1, 64};
    tbl[10] = '{1'b0, 4'b1111, 64'hA1,    64'hA2,    64'hA3,                 64'hABCD,   64, 1, 66, 1'b0, 0};
    tbl[11] = '{1'b0, 4'b0011, 64'hB1,    64'hB2,    64'hB3,                 64'hBEEF,   80, 0, 66, 1'b1, 15};
    tbl[12] = '{1'b0, 4'b0100, 64'hC1,    64'hC2,    64'hC3,                 64'hCAFE,   4,  2, 6,  1'b0, 0};
    tbl[13] = '{1'b0, 4'b1111, 64'hD1,    64'hD2,    64'hD3,                 64'hF00D,   3,  0, 5,  1'b0, 0};

    // Reset state
    #3;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_y", rsp_y, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_enable", 64'(mm_enable_p), 64'd0);
    chk("rst_mm_a", mm_a, 64'd0);
    chk("rst_mm_m", mm_m, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    for (int t = 0; t < 13; t++) run_vec(tbl[t]);

    // Reset while the multiplier is running. The pointer is 3 here, so the
    // grant that follows reset shows that the pointer went back to 0.
    stub_d = 30;
    stub_y = 64'h5151;
    for (int i = 0; i < NR; i++) req_a[i*NB +: NB] = 64'h1000 + 64'(i);
    req_valid = 4'b0010;
    #1;
    chk("wr_ready", 64'(req_ready), 64'd2);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("wr_launch", 64'(mm_enable_p), 64'd1);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("wr_busy", 64'(busy), 64'd0);
    chk("wr_owner", 64'(owner), 64'd0);
    chk("wr_mm_a", mm_a, 64'd0);
    chk("wr_rsp_y", rsp_y, 64'd0);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("wr_enable", 64'(mm_enable_p), 64'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      force_done = (k == 5);
      #1;
      if (rsp_valid !== 4'b0 || busy !== 1'b0 || mm_enable_p !== 1'b0) bad++;
      tick();
    end
    force_done = 1'b0;
    chk("wr_quiet", 64'(bad), 64'd0);
    run_vec(tbl[13]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
